combo_digit_sender: RTL and testbench
=====================================

Name: combo_digit_sender

Overview:
Transmit side of the combination-lock digit interface. It takes a full 6-digit BCD combination in one load and serializes it, one digit per handshake, into the lock FSM's digit input. It then samples the lock's open/closed verdict. Used for automated entry and self-test of the lock on the DE1-SoC build.

Parameters:
NUM_DIGITS, 6, digits per combination
DIGIT_W, 4, bits per BCD digit
GAP_CYCLES, 2, idle cycles between accepted digits (lock settling time); legal range 0..15
RESULT_TIMEOUT, 8, cycles to wait for lock verdict after last digit before flagging timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; load code_in and begin sending
code_in  in  NUM_DIGITS*DIGIT_W  combination; digit 0 = MS nibble, sent first
digit_out  out  DIGIT_W  digit presented to lock
digit_valid  out  1  digit_out is valid
digit_ready  in  1  lock accepts digit this cycle
lock_open  in  1  lock verdict: 1 = open
lock_verdict_valid  in  1  lock_open is meaningful this cycle
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer
result_open  out  1  captured verdict, held until next start
err_code  out  1  code_in contained a digit > 9; nothing sent
err_timeout  out  1  no verdict within RESULT_TIMEOUT

Behaviour:
- Reset values: digit_out=0, digit_valid=0, busy=0, done=0, result_open=0, err_code=0, err_timeout=0. State=IDLE.
- States: IDLE, CHECK, SEND, GAP, WAIT_RES, FINISH.
- IDLE: on start=1, register code_in into shift register, clear result_open/err flags, go CHECK. busy=1 from the cycle after start.
- start while busy is ignored.
- CHECK (1 cycle): if any nibble > 9, set err_code=1 and go FINISH. No digit_valid is ever asserted. Otherwise load digit index 0 and go SEND.
- SEND: digit_valid=1, digit_out=current MS nibble. digit_out is stable while digit_valid=1 and digit_ready=0. Transfer occurs on the cycle digit_valid & digit_ready.
  - On transfer, if this was the last digit, go WAIT_RES.
  - On transfer otherwise, shift left by DIGIT_W. If GAP_CYCLES=0, stay in SEND with the next digit on the following cycle; else go GAP.
- GAP: digit_valid=0 for exactly GAP_CYCLES cycles, then SEND.
- WAIT_RES: digit_valid=0, timeout counter runs.
  - If lock_verdict_valid=1, capture result_open=lock_open and go FINISH.
  - If the counter reaches RESULT_TIMEOUT without a verdict, set err_timeout=1, keep result_open=0, go FINISH.
  - A verdict arriving on the same cycle the counter expires wins: no timeout flagged.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE. Flags hold until the next accepted start or rst.
- Minimum latency, start to done, with digit_ready tied high, GAP_CYCLES=g and verdict one cycle after the last digit: 1 (CHECK) + 6 + 5*g + 1 + 1 cycles.
- rst mid-transfer: immediate return to reset values on the next edge. No partial digit is held valid.
- The digit counter is sized $clog2(NUM_DIGITS). It never wraps past NUM_DIGITS-1.

Optional Feature:
Macro COMBO_DIGIT_SENDER_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in any busy state drops digit_valid that cycle and goes FINISH. FINISH pulses done with result_open=0 and sets an added output err_abort=1. abort has priority over a simultaneous transfer: the digit is counted as not sent.
- Undefined: no abort/err_abort ports; the transfer always runs to completion or timeout.

Decomposition:
- Package combo_pkg holds:
  - typedef enum for the sender states;
  - typedef logic [3:0] digit_t;
  - localparam MAX_BCD = 9;
  - localparam default NUM_DIGITS = 6, shared with the lock FSM;
  - lock-test code constant 24'h946222.
- One natural sub-module: bcd_code_check. It is combinational, flags any nibble > 9 across NUM_DIGITS nibbles, and is reusable by the lock.

Test Plan:
- Correct code: start with code_in=24'h946222, ready high, GAP_CYCLES=2, lock returns verdict open -> digits 9,4,6,2,2,2 in order, each separated by exactly 2 idle cycles; result_open=1; done pulses once; err flags 0.
- Invalid digit: code_in=24'h94B222 -> err_code=1 and done pulse 2 cycles after start; digit_valid never asserted.
- Backpressure: hold digit_ready low 5 cycles on digit 3 -> digit_out stays 6 with digit_valid high throughout; sequence resumes unchanged.
- Timeout: no lock_verdict_valid after last digit -> err_timeout=1 exactly RESULT_TIMEOUT cycles after WAIT_RES entry; result_open=0.
- Reset mid-transfer: rst after third digit (6) accepted -> next cycle all outputs at reset values. A new start with 24'h946222 runs a full clean transfer.
- Start while busy: second start pulse during SEND with a different code -> ignored; original digits complete unchanged.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared types and constants for the combination-lock digit interface.
package combo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SEND,
    GAP,
    WAIT_RES,
    FINISH
  } sender_state_t;

  typedef logic [3:0] digit_t;

  localparam int MAX_BCD            = 9;
  localparam int DEFAULT_NUM_DIGITS = 6;
  localparam logic [23:0] LOCK_TEST_CODE = 24'h946222;

endpackage

// File: rtl/bcd_code_check.sv
// Combinational check that flags any nibble of a packed BCD code above 9.
module bcd_code_check
  import combo_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int DIGIT_W    = 4
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
  output logic                          bad
);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (code[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_BCD)) bad = 1'b1;
    end
  end

endmodule

// File: rtl/combo_digit_sender.sv
// Serializes a BCD combination into the lock digit port and captures its verdict.
// Optional abort input/err_abort output enabled by COMBO_DIGIT_SENDER_ABORT_EN.
module combo_digit_sender
  import combo_pkg::*;
#(
  parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
  parameter int DIGIT_W        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int RESULT_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code_in,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic                          digit_valid,
  input  logic                          digit_ready,
  input  logic                          lock_open,
  input  logic                          lock_verdict_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          result_open,
  output logic                          err_code,
  output logic                          err_timeout
`ifdef COMBO_DIGIT_SENDER_ABORT_EN
  ,
  input  logic                          abort,
  output logic                          err_abort
`endif
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW     = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

  sender_state_t     state, state_nxt;
  logic [CODE_W-1:0] shreg;
  logic [CW-1:0]     dig_cnt;
  logic [3:0]        gap_cnt;
  logic [TW-1:0]     tmr;
  logic              code_bad;
  logic              abort_now;
  logic              xfer;
  logic              tmr_expired;

  bcd_code_check #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_check (
    .code (shreg),
    .bad  (code_bad)
  );

`ifdef COMBO_DIGIT_SENDER_ABORT_EN
  assign abort_now = abort && (state != IDLE) && (state != FINISH);
`else
  assign abort_now = 1'b0;
`endif

  // Abort outranks a transfer in the same cycle, so the digit is not counted.
  assign xfer        = (state == SEND) && digit_ready && !abort_now;
  assign tmr_expired = (tmr == TW'(RESULT_TIMEOUT - 1));

  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign digit_valid = (state == SEND) && !abort_now;
  assign digit_out   = (state == SEND) ? shreg[CODE_W-1 -: DIGIT_W] : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = CHECK;
      CHECK:    state_nxt = code_bad ? FINISH : SEND;
      SEND: begin
        if (xfer) begin
          if (dig_cnt == LAST_DIGIT) state_nxt = WAIT_RES;
          else if (GAP_CYCLES == 0)  state_nxt = SEND;
          else                       state_nxt = GAP;
        end
      end
      GAP:      if (gap_cnt == 4'(GAP_CYCLES - 1)) state_nxt = SEND;
      WAIT_RES: if (lock_verdict_valid || tmr_expired) state_nxt = FINISH;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort_now) state_nxt = FINISH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      dig_cnt     <= '0;
      gap_cnt     <= '0;
      tmr         <= '0;
      result_open <= 1'b0;
      err_code    <= 1'b0;
      err_timeout <= 1'b0;
`ifdef COMBO_DIGIT_SENDER_ABORT_EN
      err_abort   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (!abort_now) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              shreg       <= code_in;
              dig_cnt     <= '0;
              result_open <= 1'b0;
              err_code    <= 1'b0;
              err_timeout <= 1'b0;
`ifdef COMBO_DIGIT_SENDER_ABORT_EN
              err_abort   <= 1'b0;
`endif
            end
          end
          CHECK: if (code_bad) err_code <= 1'b1;
          SEND: begin
            if (xfer) begin
              gap_cnt <= '0;
              tmr     <= '0;
              if (dig_cnt != LAST_DIGIT) begin
                shreg   <= shreg << DIGIT_W;
                dig_cnt <= dig_cnt + 1'b1;
              end
            end
          end
          GAP: gap_cnt <= gap_cnt + 1'b1;
          // A verdict on the expiry cycle takes precedence over the timeout.
          WAIT_RES: begin
            tmr <= tmr + 1'b1;
            if (lock_verdict_valid) result_open <= lock_open;
            else if (tmr_expired)   err_timeout <= 1'b1;
          end
          default: ;
        endcase
      end
`ifdef COMBO_DIGIT_SENDER_ABORT_EN
      else begin
        err_abort   <= 1'b1;
        result_open <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_combo_digit_sender.sv
// Scoreboard bench for combo_digit_sender: stimulus queues expected digits/results, a monitor checks them.
module tb_combo_digit_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] code_in = '0;
  logic [3:0]  digit_out;
  logic        digit_valid;
  logic        digit_ready = 1'b1;
  logic        lock_open = 1'b0;
  logic        lock_verdict_valid = 1'b0;
  logic        busy, done, result_open, err_code, err_timeout;

  combo_digit_sender dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .code_in            (code_in),
    .digit_out          (digit_out),
    .digit_valid        (digit_valid),
    .digit_ready        (digit_ready),
    .lock_open          (lock_open),
    .lock_verdict_valid (lock_verdict_valid),
    .busy               (busy),
    .done               (done),
    .result_open        (result_open),
    .err_code           (err_code),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic open;
    logic ec;
    logic et;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   xfers = 0;
  int   valid_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  int   xfer_cyc[$];
  logic [3:0] exp_dig[$];
  res_t exp_res[$];
  logic [3:0] code_digits [6] = '{4'd9, 4'd4, 4'd6, 4'd2, 4'd2, 4'd2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every accepted digit and every done pulse against the queues.
  initial begin
    logic       prev_stall;
    logic [3:0] prev_dig;
    res_t       r;
    prev_stall = 1'b0;
    prev_dig   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (digit_valid && prev_stall) check("stall_hold", digit_out, prev_dig);
        if (digit_valid) valid_cnt++;
        if (digit_valid && digit_ready) begin
          check("digit_expected", exp_dig.size() != 0, 1);
          if (exp_dig.size() != 0) check("digit", digit_out, exp_dig.pop_front());
          xfer_cyc.push_back(cyc);
          xfers++;
        end
        prev_stall = digit_valid && !digit_ready;
        prev_dig   = digit_out;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("result_expected", exp_res.size() != 0, 1);
          if (exp_res.size() != 0) begin
            r = exp_res.pop_front();
            check("result_open", result_open, r.open);
            check("err_code", err_code, r.ec);
            check("err_timeout", err_timeout, r.et);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_digits();
    for (int i = 0; i < 6; i++) exp_dig.push_back(code_digits[i]);
  endtask

  task automatic push_res(input logic open, input logic ec, input logic et);
    res_t r;
    r.open = open;
    r.ec   = ec;
    r.et   = et;
    exp_res.push_back(r);
  endtask

  task automatic do_start(input logic [23:0] code);
    tick();
    start     = 1'b1;
    code_in   = code;
    start_cyc = cyc;
    xfers     = 0;
    xfer_cyc.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    int g = 0;
    while (xfers < n && g < 300) begin
      tick();
      g++;
    end
    check("wait_xfers", xfers >= n, 1);
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while (done_cnt < n && g < 300) begin
      tick();
      g++;
    end
    check("wait_done", done_cnt >= n, 1);
  endtask

  task automatic give_verdict(input logic open);
    lock_open          = open;
    lock_verdict_valid = 1'b1;
    tick();
    lock_verdict_valid = 1'b0;
    lock_open          = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit_out"}, digit_out, 0);
    check({tag, "_digit_valid"}, digit_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result_open"}, result_open, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, v0, g, last;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Correct code, gap of 2, lock opens one cycle after the last digit.
    d0 = done_cnt;
    push_digits();
    push_res(1'b1, 1'b0, 1'b0);
    do_start(24'h946222);
    check("busy_after_start", busy, 1);
    wait_xfers(6);
    give_verdict(1'b1);
    wait_done(d0 + 1);
    check("first_digit_cycle", xfer_cyc[0] - start_cyc, 2);
    for (int i = 1; i < 6; i++) check("gap_spacing", xfer_cyc[i] - xfer_cyc[i-1], 3);
    check("done_latency", done_cyc - start_cyc, 19);
    tick();
    check("busy_after_done", busy, 0);
    check("done_single", done_cnt, d0 + 1);
    check("result_held", result_open, 1);

    // Invalid nibble: error and done two cycles after start, no digits.
    d0 = done_cnt;
    v0 = valid_cnt;
    push_res(1'b0, 1'b1, 1'b0);
    do_start(24'h94B222);
    wait_done(d0 + 1);
    check("err_done_latency", done_cyc - start_cyc, 2);
    tick();
    check("no_valid_on_err", valid_cnt, v0);
    check("err_code_held", err_code, 1);

    // Backpressure on digit 3 for five cycles; lock reports closed.
    d0 = done_cnt;
    push_digits();
    push_res(1'b0, 1'b0, 1'b0);
    do_start(24'h946222);
    wait_xfers(2);
    digit_ready = 1'b0;
    g = 0;
    while (!digit_valid && g < 20) begin
      tick();
      g++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", digit_valid, 1);
      check("bp_digit", digit_out, 6);
      tick();
    end
    digit_ready = 1'b1;
    wait_xfers(6);
    give_verdict(1'b0);
    wait_done(d0 + 1);
    check("bp_xfers", xfers, 6);

    // No verdict: timeout exactly RESULT_TIMEOUT cycles after WAIT_RES entry.
    d0 = done_cnt;
    push_digits();
    push_res(1'b0, 1'b0, 1'b1);
    do_start(24'h946222);
    wait_xfers(6);
    last = xfer_cyc[5];
    check("wait_res_entry", cyc, last + 1);
    repeat (7) tick();
    check("timeout_not_yet", err_timeout, 0);
    tick();
    check("timeout_flag", err_timeout, 1);
    check("timeout_done", done, 1);
    wait_done(d0 + 1);
    check("timeout_done_cycle", done_cyc, last + 9);

    // Reset after the third digit, then a clean full transfer.
    push_digits();
    push_res(1'b1, 1'b0, 1'b0);
    do_start(24'h946222);
    wait_xfers(3);
    rst = 1'b1;
    exp_dig.delete();
    exp_res.delete();
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    d0 = done_cnt;
    push_digits();
    push_res(1'b1, 1'b0, 1'b0);
    do_start(24'h946222);
    wait_xfers(6);
    give_verdict(1'b1);
    wait_done(d0 + 1);
    check("post_rst_latency", done_cyc - start_cyc, 19);

    // A second start during SEND must be ignored.
    d0 = done_cnt;
    push_digits();
    push_res(1'b1, 1'b0, 1'b0);
    do_start(24'h946222);
    wait_xfers(1);
    g = 0;
    while (!digit_valid && g < 20) begin
      tick();
      g++;
    end
    start   = 1'b1;
    code_in = 24'h111111;
    tick();
    start = 1'b0;
    wait_xfers(6);
    give_verdict(1'b1);
    wait_done(d0 + 1);
    repeat (3) tick();
    check("busy_start_single_done", done_cnt, d0 + 1);
    check("digits_drained", exp_dig.size(), 0);
    check("results_drained", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
